// File: rtl/accel_burst_reader_if.sv
// Signal bundle between accel_burst_reader, the ADXL345 SPI slave and the axis consumer.
// overrun_cnt is present only when ACCEL_BURST_OVR_EN is defined.
interface accel_burst_reader_if #(
    parameter int NUM_CH = 3
);
    logic                 start;
    logic                 busy;
    logic                 CS;
    logic                 spi_clk;
    logic                 MOSI;
    logic                 MISO;
    logic [16*NUM_CH-1:0] ch_data;
    logic                 out_valid;
    logic                 out_ack;
`ifdef ACCEL_BURST_OVR_EN
    logic [7:0]           overrun_cnt;
`endif

    modport master (
        input  start, MISO, out_ack,
        output busy, CS, spi_clk, MOSI, ch_data, out_valid
`ifdef ACCEL_BURST_OVR_EN
        , output overrun_cnt
`endif
    );

    modport slave (
        output start, MISO, out_ack,
        input  busy, CS, spi_clk, MOSI, ch_data, out_valid
`ifdef ACCEL_BURST_OVR_EN
        , input overrun_cnt
`endif
    );
endinterface

// File: rtl/accel_burst_reader.sv
// SPI mode-3 burst reader for the ADXL345 data registers; one start yields NUM_CH signed words.
// Define ACCEL_BURST_OVR_EN to add the saturating overrun_cnt output.
//
//   state | meaning
//   IDLE  | waiting for start, CS high, spi_clk high
//   SETUP | CS low, spi_clk high for CLK_DIV cycles
//   XFER  | command + data bits, CLK_DIV low then CLK_DIV high per bit
//   HOLD  | spi_clk high, CS low for CLK_DIV cycles
//   DONE  | CS high, buffer published to ch_data, out_valid set
module accel_burst_reader #(
    parameter int         CLK_DIV    = 4,
    parameter int         NUM_CH     = 3,
    parameter logic [5:0] START_ADDR = 6'h32
) (
    input  logic                 clk,
    input  logic                 rst,
    accel_burst_reader_if.master bus
);
    localparam int DATA_W = 16 * NUM_CH;
    localparam int BITS   = 8 * (1 + 2 * NUM_CH);
    localparam int BIT_W  = $clog2(BITS);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam logic       MB  = (NUM_CH * 2 > 1) ? 1'b1 : 1'b0;
    localparam logic [7:0] CMD = {1'b1, MB, START_ADDR};
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   ch_data_q, ch_data_d;
    logic                out_valid_q, out_valid_d;

    logic                div_tc;
    logic                last_bit;
    logic [BIT_W-1:0]    bit_nxt;
    logic [BIT_W-1:0]    dbit;
    logic [IDX_W-1:0]    buf_idx;
    logic [7:0]          cmd_byte;

    assign cmd_byte = CMD;
    assign div_tc   = (div_q == '0);
    assign last_bit = (bit_q == BIT_W'(BITS - 1));
    assign bit_nxt  = bit_q + 1'b1;
    assign dbit     = bit_q - BIT_W'(8);
    // Bytes land little-endian per channel but arrive MSB-first, so flip the bit-in-byte index.
    assign buf_idx  = IDX_W'(dbit ^ BIT_W'(7));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            buf_q       <= '0;
            ch_data_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            buf_q       <= buf_d;
            ch_data_q   <= ch_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (div_tc) state_d = XFER;
            XFER:    if (div_tc && sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (div_tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        buf_d       = buf_q;
        ch_data_d   = ch_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus.out_ack) out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_d  = DIV_LOAD;
                sclk_d = 1'b1;
                mosi_d = 1'b0;
            end
            SETUP: begin
                if (div_tc) begin
                    div_d  = DIV_LOAD;
                    bit_d  = '0;
                    sclk_d = 1'b0;
                    mosi_d = cmd_byte[7];
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            XFER: begin
                if (!div_tc) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (bit_q >= BIT_W'(8)) buf_d[buf_idx] = bus.MISO;
                    end else if (!last_bit) begin
                        bit_d  = bit_nxt;
                        sclk_d = 1'b0;
                        mosi_d = (bit_nxt < BIT_W'(8)) ? cmd_byte[~bit_nxt[2:0]] : 1'b0;
                    end else begin
                        mosi_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (!div_tc) div_d = div_q - 1'b1;
            end
            DONE: begin
                ch_data_d   = buf_q;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase

        cs_d = !((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD));
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.CS        = cs_q;
    assign bus.spi_clk   = sclk_q;
    assign bus.MOSI      = mosi_q;
    assign bus.ch_data   = ch_data_q;
    assign bus.out_valid = out_valid_q;

`ifdef ACCEL_BURST_OVR_EN
    logic [7:0] ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_q <= '0;
        else     ovr_q <= ovr_d;
    end

    always_comb begin
        ovr_d = ovr_q;
        if ((state_q == DONE) && out_valid_q && !bus.out_ack && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;
    end

    assign bus.overrun_cnt = ovr_q;
`endif
endmodule

// File: tb/tb_accel_burst_reader.sv
// Scoreboard bench for accel_burst_reader: SPI slave model, burst-level reference, decoupled monitor.
module tb_accel_burst_reader;
    localparam int         NUM_CH     = 3;
    localparam int         CLK_DIV    = 4;
    localparam logic [5:0] START_ADDR = 6'h32;
    localparam int         NB         = 2 * NUM_CH;
    localparam int         BITS       = 8 * (1 + NB);
    localparam int         LAT        = 2 + CLK_DIV * (2 + 2 * BITS);
    localparam logic [7:0] EXP_CMD    = 8'hF2;
    localparam int         DW         = 16 * NUM_CH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    accel_burst_reader_if #(.NUM_CH(NUM_CH)) bi();

    accel_burst_reader #(
        .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .START_ADDR(START_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bi)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]  sbytes [NB];
    int          rises    = 0;
    int          rst_cnt  = 0;
    bit          valid_m  = 0;
    int          ovr_m    = 0;
    logic [DW-1:0] data_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_words();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) w[16*k +: 16] = {sbytes[2*k+1], sbytes[2*k]};
        return w;
    endfunction

    function automatic logic slave_bit(input int r);
        logic [7:0] by;
        int d;
        if (r < 8) return 1'b0;
        d  = r - 8;
        by = sbytes[d / 8];
        return by[3'(7 - (d % 8))];
    endfunction

    // SPI slave: MISO is wrong except in the last clk cycle before each rising edge.
    initial begin : slave
        logic [7:0] cmd_rx;
        bit   mosi_ok, zero_ok, in_frame;
        logic mosi_fall, b;
        int   rc0;
        bi.MISO = 1'b0;
        @(negedge rst);
        forever begin
            @(negedge bi.CS);
            rc0 = rst_cnt; rises = 0; cmd_rx = '0;
            mosi_ok = 1; zero_ok = 1; in_frame = 1; mosi_fall = bi.MOSI;
            while (in_frame) begin
                @(bi.spi_clk or posedge bi.CS);
                if (bi.CS) begin
                    in_frame = 0;
                end else if (!bi.spi_clk) begin
                    #1;
                    mosi_fall = bi.MOSI;
                    b = slave_bit(rises);
                    bi.MISO = ~b;
                    repeat (CLK_DIV - 1) @(posedge clk);
                    #1 bi.MISO = b;
                end else begin
                    if (bi.MOSI !== mosi_fall) mosi_ok = 0;
                    if (rises < 8) cmd_rx = {cmd_rx[6:0], bi.MOSI};
                    else if (bi.MOSI !== 1'b0) zero_ok = 0;
                    rises++;
                    #1 bi.MISO = ~bi.MISO;
                end
            end
            if (rst_cnt == rc0) begin
                check("spi_rise_count", 64'(rises), 64'(BITS));
                check("mosi_cmd", 64'(cmd_rx), 64'(EXP_CMD));
                check("mosi_stable_at_rise", 64'(mosi_ok), 64'd1);
                check("mosi_zero_after_cmd", 64'(zero_ok), 64'd1);
            end
        end
    end

    // Monitor: a busy fall marks a completed burst; compare against the scoreboard head.
    initial begin : monitor
        bit prev_busy;
        logic [DW-1:0] e;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 0;
            end else begin
                if (prev_busy && !bi.busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_burst", 64'(bi.ch_data), 64'd0);
                        if (bi.ch_data === '0) begin
                            failures++;
                            $display("FAIL unexpected_burst: got burst expected none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("ch_data", 64'(bi.ch_data), 64'(e));
                        check("mon_out_valid", 64'(bi.out_valid), 64'd1);
                    end
                end
                prev_busy = bi.busy;
            end
        end
    end

    // ack_mode: 0 ack after burst, 1 leave unacknowledged, 2 ack during the DONE cycle
    task automatic run_burst(input int ack_mode);
        logic [DW-1:0] w;
        bit prev_v, busy_ok;
        int cyc;
        w = model_words();
        exp_q.push_back(w);
        prev_v = valid_m;
        busy_ok = 1;
        @(posedge clk); #1 bi.start = 1'b1;
        @(posedge clk); #1 bi.start = 1'b0;
        cyc = 1;
        while (cyc < LAT) begin
            if (bi.busy !== 1'b1) busy_ok = 0;
            if (cyc == LAT - 1) check("valid_before_done", 64'(bi.out_valid), 64'(prev_v));
            bi.start   = (cyc == 10 || cyc == 200 || cyc == LAT - 1);
            bi.out_ack = (ack_mode == 2 && cyc == LAT - 1);
            @(posedge clk); #1 cyc++;
        end
        bi.start = 1'b0; bi.out_ack = 1'b0;
        check("busy_continuous", 64'(busy_ok), 64'd1);
        check("latency_valid", 64'(bi.out_valid), 64'd1);
        check("busy_clear_at_done", 64'(bi.busy), 64'd0);
        if (prev_v && ack_mode != 2 && ovr_m < 255) ovr_m++;
        valid_m = 1; data_m = w;
`ifdef ACCEL_BURST_OVR_EN
        check("overrun_cnt", 64'(bi.overrun_cnt), 64'(ovr_m));
`endif
        repeat (3) @(posedge clk);
        #1;
        check("start_in_done_dropped", 64'(bi.busy), 64'd0);
        check("idle_cs_sclk", 64'({bi.CS, bi.spi_clk}), 64'd3);
        if (ack_mode == 0) begin
            bi.out_ack = 1'b1;
            @(posedge clk); #1 bi.out_ack = 1'b0;
            valid_m = 0;
            check("ack_clears_valid", 64'(bi.out_valid), 64'd0);
            bi.out_ack = 1'b1;
            @(posedge clk); #1 bi.out_ack = 1'b0;
            check("ack_idle_no_effect", 64'(bi.out_valid), 64'd0);
        end
        check("ch_data_hold", 64'(bi.ch_data), 64'(data_m));
    endtask

    task automatic randomize_bytes();
        for (int j = 0; j < NB; j++) sbytes[j] = 8'($urandom_range(0, 255));
    endtask

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int modes [5];
        modes = '{1, 1, 2, 0, 1};
        bi.start = 1'b0; bi.out_ack = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 64'(bi.CS), 64'd1);
        check("rst_sclk", 64'(bi.spi_clk), 64'd1);
        check("rst_mosi", 64'(bi.MOSI), 64'd0);
        check("rst_busy", 64'(bi.busy), 64'd0);
        check("rst_valid", 64'(bi.out_valid), 64'd0);
        check("rst_ch_data", 64'(bi.ch_data), 64'd0);
`ifdef ACCEL_BURST_OVR_EN
        check("rst_overrun", 64'(bi.overrun_cnt), 64'd0);
`endif
        @(posedge clk); #2 rst = 1'b0;

        sbytes = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80};
        run_burst(0);

        for (int i = 0; i < 5; i++) begin
            randomize_bytes();
            run_burst(modes[i]);
        end

        randomize_bytes();
        @(posedge clk); #1 bi.start = 1'b1;
        @(posedge clk); #1 bi.start = 1'b0;
        cyc = 0;
        while (rises < 30 && cyc < 2000) begin
            @(posedge clk); #1 cyc++;
        end
        check("reached_bit30", 64'(rises >= 30), 64'd1);
        #1;
        rst_cnt++;
        rst = 1'b1;
        #1;
        check("abort_cs", 64'(bi.CS), 64'd1);
        check("abort_sclk", 64'(bi.spi_clk), 64'd1);
        check("abort_valid", 64'(bi.out_valid), 64'd0);
        check("abort_ch_data", 64'(bi.ch_data), 64'd0);
        check("abort_busy", 64'(bi.busy), 64'd0);
        valid_m = 0; ovr_m = 0; data_m = '0;
        @(posedge clk); #2 rst = 1'b0;

        randomize_bytes();
        run_burst(0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
